// File: rtl/rx_os_lane_tracker.sv
// Per-lane consecutive ordered-set match tracker feeding the Rx LTSSM; reports success or timeout per check window.
// Optional per-lane mismatch statistics are built when OS_LANE_STATS_EN is defined.
module rx_os_lane_tracker #(
    parameter int NUM_LANES   = 16,
    parameter int OS_WIDTH    = 128,
    parameter int CNT_WIDTH   = 5,
    parameter int TIMER_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [NUM_LANES-1:0]           active_lanes,
    input  logic [CNT_WIDTH-1:0]           threshold,
    input  logic [TIMER_WIDTH-1:0]         timeout_cycles,
    input  logic                           os_valid,
    input  logic [NUM_LANES*OS_WIDTH-1:0]  ordered_sets,
    input  logic [OS_WIDTH-1:0]            os_expect,
    input  logic [OS_WIDTH-1:0]            os_mask,
    output logic                           busy,
    output logic                           done,
    output logic                           success,
    output logic                           timeout,
    output logic [NUM_LANES-1:0]           lane_done,
    output logic [NUM_LANES*CNT_WIDTH-1:0] lane_counts,
    output logic [NUM_LANES*8-1:0]         lane_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   busy_q, done_q, success_q, timeout_q;
    logic [NUM_LANES-1:0]   act_q;
    logic [CNT_WIDTH-1:0]   thr_q;
    logic [TIMER_WIDTH-1:0] tmr_q, tmr_d;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_LANES];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_LANES];
    logic [NUM_LANES-1:0]   lane_match;
    logic                   start_win, run_upd, all_ok, expiry;

    assign start_win = (state_q == S_IDLE) && start;
    assign run_upd   = (state_q == S_RUN) && !abort && os_valid;

    always_comb begin
        lane_match = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_match[i] = (((ordered_sets[i*OS_WIDTH +: OS_WIDTH] ^ os_expect) & os_mask) == '0);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (start_win) begin
                cnt_d[i] = '0;
            end else if (run_upd) begin
                if (!lane_match[i]) begin
                    cnt_d[i] = '0;
                end else if (!(&cnt_q[i])) begin
                    cnt_d[i] = cnt_q[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_comb begin
        lane_done   = '0;
        lane_counts = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_done[i]                           = (cnt_q[i] >= thr_q);
            lane_counts[i*CNT_WIDTH +: CNT_WIDTH]  = cnt_q[i];
        end
    end

    assign all_ok = (act_q != '0) && (&(lane_done | ~act_q));

    // Timer only runs for a nonzero programmed window; expiry is the 1->0 step.
    assign expiry = (state_q == S_RUN) && (timeout_cycles != '0) &&
                    (tmr_q == {{(TIMER_WIDTH-1){1'b0}}, 1'b1});

    always_comb begin
        tmr_d = tmr_q;
        if (start_win) begin
            tmr_d = timeout_cycles;
        end else if ((state_q == S_RUN) && (tmr_q != '0) && (timeout_cycles != '0)) begin
            tmr_d = tmr_q - {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            tmr_q <= tmr_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Threshold resets to all-ones so zeroed counts do not report lane_done out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            success_q <= 1'b0;
            timeout_q <= 1'b0;
            act_q     <= '0;
            thr_q     <= '1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        success_q <= 1'b0;
                        timeout_q <= 1'b0;
                        act_q     <= active_lanes;
                        thr_q     <= threshold;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (all_ok) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        success_q <= 1'b1;
                    end else if (expiry) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign success = success_q;
    assign timeout = timeout_q;

`ifdef OS_LANE_STATS_EN
    logic [7:0] err_q [NUM_LANES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                err_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (start_win) begin
                    err_q[i] <= '0;
                end else if (run_upd && !lane_match[i] && (err_q[i] != 8'hFF)) begin
                    err_q[i] <= err_q[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        lane_err_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_err_cnt[i*8 +: 8] = err_q[i];
        end
    end
`else
    assign lane_err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_os_lane_tracker.sv
// Directed bench for rx_os_lane_tracker: 4 lanes, 32-bit ordered sets, 5-bit counters.
module tb_rx_os_lane_tracker;

    localparam int NL = 4;
    localparam int OW = 32;
    localparam int CW = 5;
    localparam int TW = 24;
    localparam logic [OW-1:0] EXP  = 32'hA5A5_0F0F;
    localparam logic [OW-1:0] MASK = 32'hFFFF_00FF;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, abort, os_valid;
    logic [NL-1:0]     active_lanes;
    logic [CW-1:0]     threshold;
    logic [TW-1:0]     timeout_cycles;
    logic [NL*OW-1:0]  ordered_sets;
    logic [OW-1:0]     os_expect, os_mask;
    logic              busy, done, success, timeout;
    logic [NL-1:0]     lane_done;
    logic [NL*CW-1:0]  lane_counts;
    logic [NL*8-1:0]   lane_err_cnt;

    int checks = 0;
    int errors = 0;

    rx_os_lane_tracker #(
        .NUM_LANES(NL), .OS_WIDTH(OW), .CNT_WIDTH(CW), .TIMER_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .active_lanes(active_lanes), .threshold(threshold),
        .timeout_cycles(timeout_cycles), .os_valid(os_valid),
        .ordered_sets(ordered_sets), .os_expect(os_expect), .os_mask(os_mask),
        .busy(busy), .done(done), .success(success), .timeout(timeout),
        .lane_done(lane_done), .lane_counts(lane_counts), .lane_err_cnt(lane_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] good_os();
        logic [OW-1:0] noise;
        noise = $urandom;
        return (EXP & MASK) | (noise & ~MASK);
    endfunction

    // Lanes with good[i]=1 carry a matching OS (random don't-care bits), others a masked-in bit flip.
    task automatic send(input logic [NL-1:0] good);
        for (int i = 0; i < NL; i++) begin
            ordered_sets[i*OW +: OW] = good[i] ? good_os() : (good_os() ^ 32'h0001_0000);
        end
        os_valid = 1'b1;
        tick();
        os_valid = 1'b0;
    endtask

    task automatic open_window(input logic [NL-1:0] act, input logic [CW-1:0] thr,
                               input logic [TW-1:0] tmo);
        active_lanes   = act;
        threshold      = thr;
        timeout_cycles = tmo;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_err;
        reset = 1'b1; start = 1'b0; abort = 1'b0; os_valid = 1'b0;
        active_lanes = '0; threshold = '0; timeout_cycles = '0;
        ordered_sets = '0; os_expect = EXP; os_mask = MASK;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_succ", success, 0);
        chk("rst_tmo", timeout, 0);
        chk("rst_lane_done", lane_done, 0);
        chk("rst_counts", lane_counts, 0);
        chk("rst_err", lane_err_cnt, 0);
        reset = 1'b0;
        tick();

        // 8 matches on all lanes, done two edges after the 8th valid
        open_window(4'hF, 5'd8, 24'd0);
        chk("t1_busy", busy, 1);
        for (int n = 0; n < 8; n++) send(4'hF);
        chk("t1_counts", lane_counts, {4{5'd8}});
        chk("t1_lane_done", lane_done, 4'hF);
        chk("t1_not_done_yet", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_succ", success, 1);
        chk("t1_busy_low", busy, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_succ_held", success, 1);
        chk("t1_counts_held", lane_counts, {4{5'd8}});

        // lane 2 mismatch on OS #5 resets its run
        open_window(4'hF, 5'd8, 24'd0);
        chk("t2_succ_cleared", success, 0);
        for (int n = 0; n < 4; n++) send(4'hF);
        send(4'b1011);
        chk("t2_counts_after_err", lane_counts, {5'd5, 5'd0, 5'd5, 5'd5});
        for (int n = 0; n < 7; n++) send(4'hF);
        chk("t2_lane_done_partial", lane_done, 4'b1011);
        tick();
        chk("t2_no_done", done, 0);
        send(4'hF);
        chk("t2_counts", lane_counts, {5'd13, 5'd8, 5'd13, 5'd13});
        tick();
        chk("t2_done", done, 1);
        chk("t2_succ", success, 1);
        tick();

        // timeout of 20 cycles with no traffic
        open_window(4'hF, 5'd8, 24'd20);
        repeat (19) tick();
        chk("t3_no_done_at19", done, 0);
        chk("t3_busy_at19", busy, 1);
        tick();
        chk("t3_done", done, 1);
        chk("t3_tmo", timeout, 1);
        chk("t3_succ", success, 0);
        tick();
        chk("t3_done_pulse", done, 0);
        chk("t3_tmo_held", timeout, 1);

        // all_ok and expiry on the same edge: success wins
        open_window(4'hF, 5'd3, 24'd4);
        chk("t4_tmo_cleared", timeout, 0);
        for (int n = 0; n < 3; n++) send(4'hF);
        chk("t4_no_done", done, 0);
        tick();
        chk("t4_done", done, 1);
        chk("t4_succ", success, 1);
        chk("t4_tmo", timeout, 0);
        tick();

        // abort: no done, busy drops next cycle, counts hold
        open_window(4'hF, 5'd8, 24'd0);
        send(4'hF); send(4'hF);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_succ", success, 0);
        chk("t5_counts", lane_counts, {4{5'd2}});
        tick(); tick();
        chk("t5_no_done_late", done, 0);

        // active lanes 0 and 2 only; lanes 1 and 3 garbage
        open_window(4'b0101, 5'd8, 24'd0);
        for (int n = 0; n < 8; n++) send(4'b0101);
        chk("t6_lane_done", lane_done, 4'b0101);
        chk("t6_counts", lane_counts, {5'd0, 5'd8, 5'd0, 5'd8});
        tick();
        chk("t6_done", done, 1);
        chk("t6_succ", success, 1);
        tick();

        // no active lanes: 40 matches saturate, then 3 lane-0 mismatches
        open_window(4'h0, 5'd8, 24'd0);
        for (int n = 0; n < 40; n++) send(4'hF);
        chk("t7_sat", lane_counts, {4{5'd31}});
        chk("t7_still_busy", busy, 1);
        chk("t7_no_done", done, 0);
        for (int n = 0; n < 3; n++) send(4'b1110);
        chk("t7_counts", lane_counts, {5'd31, 5'd31, 5'd31, 5'd0});
`ifdef OS_LANE_STATS_EN
        exp_err = 32'h0000_0003;
`else
        exp_err = 32'h0000_0000;
`endif
        chk("t7_err_cnt", lane_err_cnt, exp_err);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t7_abort_busy", busy, 0);

        // threshold 0: success on first RUN cycle
        open_window(4'hF, 5'd0, 24'd0);
        chk("t8_busy", busy, 1);
        tick();
        chk("t8_done", done, 1);
        chk("t8_succ", success, 1);
        tick();

        // reset mid-window
        open_window(4'hF, 5'd8, 24'd0);
        send(4'hF); send(4'hF);
        reset = 1'b1;
        #1;
        chk("t9_busy", busy, 0);
        chk("t9_counts", lane_counts, 0);
        chk("t9_lane_done", lane_done, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t9_idle_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
